wptr_full: RTL and testbench

WPTR_FULL -- requirements
Module: wptr_full

---
 rtl/wptr_full.sv | 86 ++++++++
 tb/tb_wptr_full.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/wptr_full.sv
// wptr_full -- write-side pointer and full-flag logic of an asynchronous FIFO.
// Keeps a binary write pointer and a registered Gray copy for the read-domain
// synchronizer. Produces registered full, almost-full and fill-level outputs,
// comparing against the read pointer that has already been synchronized into wclk.
// Optional feature: define WPTR_OVF_EN to enable the sticky overflow flag wovf.
// When it is undefined, wovf is tied to 0.
module wptr_full #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wclken,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam logic [ADDRSIZE:0] AFULL_LVL = AFULL_THRESH[ADDRSIZE:0];

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbin_next;
    logic [ADDRSIZE:0] wgray_next;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] level_next;
    logic              wfull_next;
    logic              walmost_next;

    // The memory sees the write request directly. The producer must respect wfull.
    assign wclken = winc;
    assign waddr  = wbin[ADDRSIZE-1:0];

    // Next pointer, Gray conversion, level, and flags for the coming edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
        wbin_next    = wbin + {{ADDRSIZE{1'b0}}, (winc & ~wfull)};
        wgray_next   = (wbin_next >> 1) ^ wbin_next;
        // The FIFO is full when the write pointer is one lap ahead of the read pointer.
        // In Gray code this means the two MSBs differ and all remaining bits match.
        wfull_next   = (wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                        wq2_rptr[ADDRSIZE-2:0]});
        level_next   = wbin_next - rbin;
        walmost_next = (level_next >= AFULL_LVL);
    end

    // Pointer and flag registers. Synchronous reset takes priority over writes.
    always_ff @(posedge wclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= wfull_next;
            walmost_full <= walmost_next;
            wlevel       <= level_next;
        end
    end

`ifdef WPTR_OVF_EN
    // Sticky overflow flag. It sets when a write is attempted while full, and only reset clears it.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wovf <= 1'b0;
        end else if (winc && wfull) begin
            wovf <= 1'b1;
        end
    end
`else
    assign wovf = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full.sv
// tb_wptr_full -- directed test of wptr_full with ADDRSIZE=4 and AFULL_THRESH=12.
// Each step sets the inputs, waits for a rising edge, and samples 1 time unit later.
module tb_wptr_full;

    logic       wclk = 1'b0;
    logic       wrst;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic [4:0] wptr;
    logic [3:0] waddr;
    logic       wclken;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       wovf;

    int tests = 0;
    int fails = 0;

    wptr_full #(.ADDRSIZE(4), .AFULL_THRESH(12)) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .winc        (winc),
        .wq2_rptr    (wq2_rptr),
        .wptr        (wptr),
        .waddr       (waddr),
        .wclken      (wclken),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wlevel      (wlevel),
        .wovf        (wovf)
    );

    always #5 wclk = ~wclk;

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [4:0] exp_bin;
    logic [4:0] prev_ptr;
    logic [4:0] hist1;
    logic [4:0] hist2;
    logic       exp_ovf;

    initial begin
`ifdef WPTR_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        // Reset state.
        wrst = 1'b1; winc = 1'b0; wq2_rptr = 5'd0;
        step(); step();
        check("rst_wptr", wptr, 5'd0);
        check("rst_waddr", waddr, 4'd0);
        check("rst_wfull", wfull, 1'b0);
        check("rst_afull", walmost_full, 1'b0);
        check("rst_level", wlevel, 5'd0);
        check("rst_wovf", wovf, 1'b0);
        check("rst_wclken", wclken, 1'b0);

        // Eleven writes keep the level just below the almost-full threshold.
        wrst = 1'b0; winc = 1'b1;
        #1 check("wclken_follows_winc", wclken, 1'b1);
        for (int i = 0; i < 11; i++) step();
        check("w11_level", wlevel, 5'd11);
        check("w11_afull", walmost_full, 1'b0);
        check("w11_waddr", waddr, 4'd11);
        check("w11_wptr", wptr, 5'b01110);
        check("w11_wfull", wfull, 1'b0);

        // The twelfth write reaches the threshold.
        step();
        check("w12_afull", walmost_full, 1'b1);
        check("w12_level", wlevel, 5'd12);

        // Writes 13 through 16 fill the FIFO.
        for (int i = 0; i < 4; i++) step();
        check("w16_wfull", wfull, 1'b1);
        check("w16_level", wlevel, 5'd16);
        check("w16_wptr", wptr, 5'b11000);
        check("w16_waddr", waddr, 4'd0);

        // A write while full is ignored, and it sets overflow when the feature is enabled.
        step();
        check("ovf_wptr_hold", wptr, 5'b11000);
        check("ovf_waddr_hold", waddr, 4'd0);
        check("ovf_wfull", wfull, 1'b1);
        check("ovf_level", wlevel, 5'd16);
        check("ovf_wovf", wovf, exp_ovf);

        // One read drains a slot. Full clears on the next edge.
        winc = 1'b0; wq2_rptr = 5'b00001;
        step();
        check("rd_wfull", wfull, 1'b0);
        check("rd_level", wlevel, 5'd15);
        check("rd_afull", walmost_full, 1'b1);
        check("rd_wovf_sticky", wovf, exp_ovf);

        // Fill to level 7, then reset with winc still high.
        wrst = 1'b1; wq2_rptr = 5'd0; step();
        wrst = 1'b0; winc = 1'b1;
        for (int i = 0; i < 7; i++) step();
        check("l7_level", wlevel, 5'd7);
        check("l7_waddr", waddr, 4'd7);
        wrst = 1'b1;
        step();
        check("midrst_wptr", wptr, 5'd0);
        check("midrst_waddr", waddr, 4'd0);
        check("midrst_level", wlevel, 5'd0);
        check("midrst_wfull", wfull, 1'b0);
        check("midrst_afull", walmost_full, 1'b0);
        check("midrst_wovf", wovf, 1'b0);
        wrst = 1'b0;
        step();
        check("post_rst_waddr", waddr, 4'd1);
        check("post_rst_level", wlevel, 5'd1);

        // A reset pulse with no clock edge has no effect.
        winc = 1'b0; wrst = 1'b1;
        #2;
        check("async_rst_level", wlevel, 5'd1);
        check("async_rst_waddr", waddr, 4'd1);
        wrst = 1'b0;

        // A simultaneous read and write leave the level unchanged.
        winc = 1'b1; wq2_rptr = 5'b00001;
        step();
        check("rw_level", wlevel, 5'd1);
        check("rw_waddr", waddr, 4'd2);
        check("rw_wptr", wptr, 5'b00011);

        // Streaming with the read pointer lagging two cycles: the pointer wraps and never reports full.
        wrst = 1'b1; winc = 1'b0; wq2_rptr = 5'd0; step();
        wrst = 1'b0; winc = 1'b1;
        exp_bin = 5'd0; prev_ptr = 5'd0; hist1 = 5'd0; hist2 = 5'd0;
        for (int i = 0; i < 40; i++) begin
            wq2_rptr = hist2;
            step();
            exp_bin = exp_bin + 5'd1;
            check("wrap_wptr", wptr, (exp_bin >> 1) ^ exp_bin);
            check("wrap_waddr", waddr, exp_bin[3:0]);
            check("wrap_onebit", $countones(prev_ptr ^ wptr), 32'd1);
            check("wrap_nofull", wfull, 1'b0);
            prev_ptr = wptr;
            hist2 = hist1;
            hist1 = wptr;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
